// File: rtl/servo_ramp_ctrl.sv
// APB-programmed servo pulse-width sequencer: owns PWM frame timing and slews CURRENT toward TARGET once per frame.
// Optional ramp-done interrupt compiled in with `define SERVO_RAMP_IRQ_EN.
module servo_ramp_ctrl #(
    parameter int unsigned PERIOD  = 2000000,
    parameter int unsigned MIN_PW  = 100000,
    parameter int unsigned MAX_PW  = 200000,
    parameter int unsigned INIT_PW = 150000
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] pulse_width,
    output logic        frame_start,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    localparam logic [7:0] A_TARGET  = 8'h00;
    localparam logic [7:0] A_STEP    = 8'h04;
    localparam logic [7:0] A_CTRL    = 8'h08;
    localparam logic [7:0] A_STATUS  = 8'h0C;
    localparam logic [7:0] A_CURRENT = 8'h10;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic        fs_q;
    logic [31:0] target_q;
    logic [31:0] current_q;
    logic [23:0] step_q;
    logic        en_q;
    logic        done_q;
    logic        irq_en;
    logic        wr;
    logic        w1c;
    logic [31:0] step_ext;
    logic [31:0] up_d;
    logic [31:0] dn_d;

    function automatic logic [31:0] clamp_pw(input logic [31:0] v);
        if (v < 32'(MIN_PW))
            return 32'(MIN_PW);
        else if (v > 32'(MAX_PW))
            return 32'(MAX_PW);
        else
            return v;
    endfunction

    assign wr       = PSEL & PENABLE & PWRITE;
    assign w1c      = wr && (PADDR == A_STATUS) && PWDATA[0];
    assign step_ext = {8'd0, step_q};

    // Next CURRENT for each direction; only consulted while that direction is valid.
    assign up_d = ((step_q == 24'd0) || ((target_q - current_q) <= step_ext)) ?
                  target_q : current_q + step_ext;
    assign dn_d = ((step_q == 24'd0) || ((current_q - target_q) <= step_ext)) ?
                  target_q : current_q - step_ext;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign pulse_width = current_q;
    assign frame_start = fs_q;
    assign busy        = (current_q != target_q);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cnt_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == 32'(PERIOD - 1)) ? 32'd0 : cnt_q + 32'd1;
            fs_q  <= (cnt_q == 32'(PERIOD - 1));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            target_q <= 32'(INIT_PW);
            step_q   <= '0;
            en_q     <= 1'b0;
        end else if (wr) begin
            case (PADDR)
                A_TARGET: target_q <= clamp_pw(PWDATA);
                A_STEP:   step_q   <= PWDATA[23:0];
                A_CTRL:   en_q     <= PWDATA[0];
                default: ;
            endcase
        end
    end

`ifdef SERVO_RAMP_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && (PADDR == A_CTRL))
                irq_en_q <= PWDATA[1];
            irq_q <= done_q & irq_en_q;
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    // Reversal and target-equal checks take priority so the unsigned differences never wrap.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= IDLE;
            current_q <= 32'(INIT_PW);
            done_q    <= 1'b0;
        end else begin
            if (w1c)
                done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_q && (target_q > current_q))
                        state_q <= UP;
                    else if (en_q && (target_q < current_q))
                        state_q <= DOWN;
                end
                UP: begin
                    if (!en_q || (target_q == current_q))
                        state_q <= IDLE;
                    else if (target_q < current_q)
                        state_q <= DOWN;
                    else if (fs_q) begin
                        current_q <= up_d;
                        if (up_d == target_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (!en_q || (target_q == current_q))
                        state_q <= IDLE;
                    else if (target_q > current_q)
                        state_q <= UP;
                    else if (fs_q) begin
                        current_q <= dn_d;
                        if (dn_d == target_q) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        case (PADDR)
            A_TARGET:  PRDATA = target_q;
            A_STEP:    PRDATA = step_ext;
            A_CTRL:    PRDATA = {30'd0, irq_en, en_q};
            A_STATUS:  PRDATA = {30'd0, busy, done_q};
            A_CURRENT: PRDATA = current_q;
            default:   PRDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Scoreboard bench for servo_ramp_ctrl with a 100-cycle frame; expected CURRENT values are queued and checked at each frame.
module tb_servo_ramp_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h00;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] pulse_width;
    logic        frame_start;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    servo_ramp_ctrl #(.PERIOD(100)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .pulse_width(pulse_width),
        .frame_start(frame_start), .busy(busy), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        PADDR = a;
        #1;
        d = PRDATA;
    endtask

    // Returns at the negedge inside the next frame_start cycle.
    task automatic wait_frame(output int n);
        n = 1;
        @(negedge PCLK);
        while (frame_start !== 1'b1 && n < 300) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL frame_timeout: no frame_start within %0d cycles", n);
        end
    endtask

    // Pops one expected CURRENT per frame and compares both the output and the register.
    task automatic drain_frames(input string tag);
        int n;
        int unsigned e;
        logic [31:0] rd;
        while (exp_q.size() > 0) begin
            wait_frame(n);
            @(negedge PCLK);
            e = exp_q.pop_front();
            checks++;
            if (pulse_width !== e) begin
                errors++;
                $display("FAIL %s_pw: got %0d expected %0d", tag, pulse_width, e);
            end
            apb_read(8'h10, rd);
            checks++;
            if (rd !== e) begin
                errors++;
                $display("FAIL %s_current: got %0d expected %0d", tag, rd, e);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] rd;
        repeat (3) @(negedge PCLK);
        checks++;
        if (pulse_width !== 32'd150000 || busy !== 1'b0 || frame_start !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got pw=%0d busy=%b fs=%b irq=%b expected 150000 0 0 0",
                     pulse_width, busy, frame_start, irq);
        end
        PRESETN = 1'b1;
        apb_read(8'h10, rd);
        checks++;
        if (rd !== 32'd150000) begin errors++; $display("FAIL reset_current: got %0d expected 150000", rd); end
        apb_read(8'h00, rd);
        checks++;
        if (rd !== 32'd150000) begin errors++; $display("FAIL reset_target: got %0d expected 150000", rd); end
        apb_read(8'h04, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", rd); end
        apb_read(8'h08, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %0d expected 0", rd); end
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %0d expected 0", rd); end
        apb_read(8'h40, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %0h expected 0", rd); end
        wait_frame(n);
        checks++;
        if (n !== 100) begin errors++; $display("FAIL first_frame: got %0d cycles expected 100", n); end
        wait_frame(n);
        checks++;
        if (n !== 100) begin errors++; $display("FAIL frame_period: got %0d cycles expected 100", n); end
    endtask

    task automatic test_ramp_up();
        int n;
        logic [31:0] rd;
        wait_frame(n);
        apb_write(8'h04, 32'd100);
        apb_write(8'h00, 32'd150300);
        apb_write(8'h08, 32'd1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy: got %b expected 1", busy); end
        exp_q.push_back(150100);
        exp_q.push_back(150200);
        exp_q.push_back(150300);
        drain_frames("ramp_up");
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL ramp_done_status: got %0h expected 1", rd); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end: got %b expected 0", busy); end
        apb_write(8'h0C, 32'd1);
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL done_w1c: got %0h expected 0", rd); end
    endtask

    task automatic test_clamp_jump();
        int n;
        logic [31:0] rd;
        apb_write(8'h08, 32'd0);
        apb_write(8'h00, 32'd5);
        apb_read(8'h00, rd);
        checks++;
        if (rd !== 32'd100000) begin errors++; $display("FAIL clamp_low: got %0d expected 100000", rd); end
        apb_write(8'h00, 32'hFFFF_FFFF);
        apb_read(8'h00, rd);
        checks++;
        if (rd !== 32'd200000) begin errors++; $display("FAIL clamp_high: got %0d expected 200000", rd); end
        wait_frame(n);
        @(negedge PCLK);
        checks++;
        if (pulse_width !== 32'd150300) begin
            errors++; $display("FAIL en_off_hold: got %0d expected 150300", pulse_width);
        end
        wait_frame(n);
        apb_write(8'h04, 32'd0);
        apb_write(8'h00, 32'd120000);
        apb_write(8'h08, 32'd1);
        exp_q.push_back(120000);
        drain_frames("jump");
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL jump_done: got %0h expected 1", rd); end
        apb_write(8'h0C, 32'd1);
    endtask

    task automatic test_reversal();
        int n;
        logic [31:0] rd;
        wait_frame(n);
        apb_write(8'h00, 32'd150000);
        exp_q.push_back(150000);
        drain_frames("rev_setup");
        apb_write(8'h0C, 32'd1);
        wait_frame(n);
        apb_write(8'h04, 32'd1000);
        apb_write(8'h00, 32'd152000);
        exp_q.push_back(151000);
        drain_frames("rev_up");
        apb_write(8'h00, 32'd149500);
        exp_q.push_back(150000);
        drain_frames("rev_down1");
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd2) begin errors++; $display("FAIL rev_no_done: got %0h expected 2", rd); end
        exp_q.push_back(149500);
        drain_frames("rev_down2");
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd1) begin errors++; $display("FAIL rev_done: got %0h expected 1", rd); end
        apb_write(8'h0C, 32'd1);
        exp_q.push_back(149500);
        drain_frames("rev_hold");
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL rev_done_once: got %0h expected 0", rd); end
    endtask

    task automatic test_irq();
        int n;
        logic [31:0] rd;
        logic [31:0] ctrl_exp;
        logic        irq_hi;
`ifdef SERVO_RAMP_IRQ_EN
        ctrl_exp = 32'd3;
        irq_hi   = 1'b1;
`else
        ctrl_exp = 32'd1;
        irq_hi   = 1'b0;
`endif
        wait_frame(n);
        apb_write(8'h04, 32'd0);
        apb_write(8'h08, 32'd3);
        apb_write(8'h00, 32'd150000);
        apb_read(8'h08, rd);
        checks++;
        if (rd !== ctrl_exp) begin errors++; $display("FAIL ctrl_read: got %0h expected %0h", rd, ctrl_exp); end
        wait_frame(n);
        @(negedge PCLK);
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd1 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_lag: got status=%0h irq=%b expected 1 0", rd, irq);
        end
        @(negedge PCLK);
        checks++;
        if (irq !== irq_hi) begin errors++; $display("FAIL irq_rise: got %b expected %b", irq, irq_hi); end
        apb_write(8'h0C, 32'd1);
        checks++;
        if (irq !== irq_hi) begin errors++; $display("FAIL irq_hold: got %b expected %b", irq, irq_hi); end
        @(negedge PCLK);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        apb_write(8'h08, 32'd1);
    endtask

    task automatic test_async_reset();
        int n;
        logic [31:0] rd;
        wait_frame(n);
        apb_write(8'h04, 32'd1000);
        apb_write(8'h00, 32'd200000);
        exp_q.push_back(151000);
        exp_q.push_back(152000);
        drain_frames("pre_reset");
        repeat (37) @(negedge PCLK);
        #2;
        PRESETN = 1'b0;
        #1;
        checks++;
        if (pulse_width !== 32'd150000 || busy !== 1'b0 || frame_start !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pw=%0d busy=%b fs=%b irq=%b expected 150000 0 0 0",
                     pulse_width, busy, frame_start, irq);
        end
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
        apb_read(8'h08, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL post_reset_ctrl: got %0h expected 0", rd); end
        apb_read(8'h00, rd);
        checks++;
        if (rd !== 32'd150000) begin errors++; $display("FAIL post_reset_target: got %0d expected 150000", rd); end
        wait_frame(n);
        checks++;
        if (n !== 100) begin errors++; $display("FAIL post_reset_frame: got %0d cycles expected 100", n); end
        exp_q.push_back(150000);
        drain_frames("post_reset_idle");
        apb_read(8'h0C, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL post_reset_status: got %0h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp_jump();
        test_reversal();
        test_irq();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
- APB-programmed motion sequencer for a servo PWM channel.
- Accepts a target pulse width and slews the live pulse width toward it by a programmable step once per PWM frame.
- Drives pulse_width and frame_start into the PWM generator, and owns the frame timing for that generator.
- Flags completion through STATUS and, when compiled in, an interrupt.

Parameters:
- PERIOD, 2000000: frame length in PCLK cycles (20 ms at 100 MHz).
- MIN_PW, 100000: lowest legal pulse width in cycles (1.0 ms).
- MAX_PW, 200000: highest legal pulse width in cycles (2.0 ms).
- INIT_PW, 150000: pulse width loaded at reset (centre position).

Ports:
- PCLK  in  1  system clock.
- PRESETN  in  1  reset, asynchronous assert, active-low; all state clears immediately on assertion.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write strobe.
- PADDR  in  8  APB byte address.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied 1; no wait states.
- PSLVERR  out  1  tied 0.
- pulse_width  out  32  live pulse width, to the PWM generator.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- busy  out  1  high while current != target.
- irq  out  1  ramp-done interrupt, level.

Behaviour:
- Register map (write = PSEL&PENABLE&PWRITE; reads are combinational on PADDR):
  - 0x00 TARGET rw: written value is clamped to [MIN_PW,MAX_PW] before storing.
  - 0x04 STEP rw [23:0]: slew per frame; 0 = jump to target at the next frame_start.
  - 0x08 CTRL rw: bit0 EN, bit1 IRQ_EN.
  - 0x0C STATUS: bit0 DONE (W1C), bit1 busy (ro).
  - 0x10 CURRENT ro.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset values: TARGET=CURRENT=INIT_PW, STEP=0, CTRL=0, DONE=0, frame counter=0, state IDLE, frame_start=0, busy=0, irq=0.
- Frame counter: counts 0..PERIOD-1 and wraps to 0. frame_start is registered high for the one cycle in which the counter equals 0 (i.e. the cycle after the wrap). The counter runs regardless of EN.
- pulse_width = CURRENT, registered. A change becomes visible only in the cycle after the frame_start that caused it, so the PWM never sees a mid-frame edit.
- FSM states: IDLE, UP, DOWN.
  - IDLE → UP when EN && TARGET>CURRENT.
  - IDLE → DOWN when EN && TARGET<CURRENT.
  - Evaluated every cycle.
- UP, on frame_start: CURRENT <= (STEP==0 || TARGET-CURRENT<=STEP) ? TARGET : CURRENT+STEP. Arithmetic is 32-bit unsigned; overflow is impossible after clamping.
- DOWN is symmetric: CURRENT <= TARGET when CURRENT-TARGET<=STEP, else CURRENT-STEP.
- On reaching TARGET: go to IDLE and set DONE for one event (sticky until W1C).
- TARGET rewritten mid-ramp: re-evaluated on the next cycle. A direction reversal moves UP↔DOWN without passing through IDLE, and no DONE is set for the abandoned target.
- EN cleared mid-ramp: FSM goes to IDLE and CURRENT freezes.
- busy = (CURRENT != TARGET), independent of EN.
- DONE set and W1C in the same cycle: set wins.
- PRESETN asserted mid-ramp: everything returns to reset values asynchronously; pulse_width = INIT_PW immediately.

Optional Feature:
- Macro SERVO_RAMP_IRQ_EN.
- Defined: irq = DONE & CTRL.IRQ_EN, registered. It deasserts the cycle after the DONE W1C write.
- Undefined: irq tied 0, CTRL bit1 reads 0 and ignores writes, and the DONE status bit still operates.

Test Plan:
- Reset, PERIOD=100: after PRESETN rises, pulse_width=150000, busy=0, frame_start pulses every 100 cycles, and PRDATA@0x10=150000.
- TARGET=150300, STEP=100, EN=1: CURRENT reads 150100, 150200, 150300 on three consecutive frame_starts. DONE=1 after the third; busy then drops to 0.
- TARGET=5 written → reads back 100000. TARGET=0xFFFFFFFF → reads back 200000. STEP=0 with TARGET=120000: CURRENT=120000 after exactly one frame_start.
- Ramp UP from 150000 with STEP=1000; write TARGET=149500 after the first frame: next frame CURRENT=150000, following frame 149500, with DONE set exactly once.
- SERVO_RAMP_IRQ_EN defined, IRQ_EN=1: irq rises the cycle after DONE sets; writing 1 to STATUS bit0 clears irq the next cycle. With the macro undefined, irq stays 0 throughout.
- Assert PRESETN asynchronously mid-ramp (mid-frame, off a clock edge): pulse_width returns to 150000 with no clock edge, and the state is IDLE after release.
